mar_burst: RTL and testbench

Parametrised memory address register for the core's memory path. It holds the current memory address and supports direct load and single-step increment. It also runs an autonomous burst engine that steps the address across N beats under a req/ack handshake with memory, so the control unit can issue multi-word transfers without re-driving the address every cycle.

---
 rtl/mar_pkg.sv | 34 +++
 rtl/mar_step.sv | 25 ++
 rtl/mar_burst.sv | 121 ++++++++++++
 tb/tb_mar_burst.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mar_pkg.sv
// Shared definitions for address generators: FSM state encoding and the
// carry-aware address step (wrap or saturate on overflow).
package mar_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int MAX_AW = 32;

  // Result is {overflow, next address}; operands must already fit in aw bits.
  function automatic logic [MAX_AW:0] step_addr(
    input logic [MAX_AW-1:0] a,
    input logic [MAX_AW-1:0] step,
    input int                aw,
    input logic              wrap
  );
    logic [MAX_AW:0] mask;
    logic [MAX_AW:0] sum;
    logic            ovf;
    mask = (33'd1 << aw) - 33'd1;
    sum  = {1'b0, a} + {1'b0, step};
    ovf  = (sum & ~mask) != '0;
    if (!ovf)
      return {1'b0, sum[MAX_AW-1:0]};
    else if (wrap)
      return {1'b1, sum[MAX_AW-1:0] & mask[MAX_AW-1:0]};
    else
      return {1'b1, mask[MAX_AW-1:0]};
  endfunction

endpackage

// File: rtl/mar_step.sv
// Combinational address stepper: next = addr + STEP with wrap or saturate.
// Supports AW from 1 to 31.
module mar_step
  import mar_pkg::*;
#(
  parameter int AW   = 5,
  parameter int STEP = 1,
  parameter int WRAP = 1
) (
  input  logic [AW-1:0] addr,
  output logic [AW-1:0] next_addr,
  output logic          ovf
);

  localparam logic [AW-1:0] step_a = AW'(STEP);

  logic [MAX_AW:0] res;
  logic            unused_hi;

  assign res       = step_addr(MAX_AW'(addr), MAX_AW'(step_a), AW, WRAP != 0);
  assign next_addr = res[AW-1:0];
  assign ovf       = res[MAX_AW];
  assign unused_hi = ^res[MAX_AW-1:AW];

endmodule

// File: rtl/mar_burst.sv
// Memory address register with load, single step and a req/ack burst engine.
// Optional bounds checking against LIMIT is enabled by MAR_BOUNDS_CHECK_EN.
module mar_burst
  import mar_pkg::*;
#(
  parameter int AW    = 5,
  parameter int LW    = 4,
  parameter int STEP  = 1,
  parameter int WRAP  = 1,
  parameter int LIMIT = (1 << AW) - 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld,
  input  logic [AW-1:0] addr_in,
  input  logic          inc,
  input  logic          burst_start,
  input  logic [LW-1:0] burst_len,
  input  logic          mem_ack,
  output logic [AW-1:0] addr,
  output logic          mem_req,
  output logic          busy,
  output logic          done,
  output logic          fault
);

  state_t        state, state_next;
  logic [LW-1:0] cnt, cnt_next;
  logic [AW-1:0] addr_next, step_next;
  logic          unused_ovf;
  logic          load_ok, step_ok;
  logic          fault_q, fault_next;

  mar_step #(.AW(AW), .STEP(STEP), .WRAP(WRAP)) u_step (
    .addr      (addr),
    .next_addr (step_next),
    .ovf       (unused_ovf)
  );

`ifdef MAR_BOUNDS_CHECK_EN
  localparam logic [AW-1:0] limit_addr = AW'(LIMIT);
  assign load_ok = addr_in <= limit_addr;
  assign step_ok = step_next <= limit_addr;
  assign fault   = fault_q;
`else
  localparam int unused_limit = LIMIT;
  assign load_ok = 1'b1;
  assign step_ok = 1'b1;
  assign fault   = 1'b0;
`endif

  always_comb begin
    state_next = state;
    addr_next  = addr;
    cnt_next   = cnt;
    fault_next = fault_q;
    case (state)
      BURST: begin
        // ld aborts the burst even when the same cycle acks a beat
        if (ld) begin
          state_next = IDLE;
          if (load_ok) begin
            addr_next  = addr_in;
            fault_next = 1'b0;
          end else begin
            fault_next = 1'b1;
          end
        end else if (mem_ack) begin
          if (cnt == '0) begin
            state_next = DONE;
          end else if (step_ok) begin
            addr_next = step_next;
            cnt_next  = cnt - 1'b1;
          end else begin
            fault_next = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        if (ld) begin
          if (load_ok) begin
            addr_next  = addr_in;
            fault_next = 1'b0;
          end else begin
            fault_next = 1'b1;
          end
        end else if (burst_start) begin
          cnt_next   = burst_len;
          state_next = BURST;
        end else if (inc) begin
          if (step_ok) addr_next = step_next;
          else         fault_next = 1'b1;
        end
      end
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr    <= '0;
      cnt     <= '0;
      fault_q <= 1'b0;
      mem_req <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      addr    <= addr_next;
      cnt     <= cnt_next;
      fault_q <= fault_next;
      mem_req <= (state_next == BURST);
      busy    <= (state_next == BURST);
      done    <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_mar_burst.sv
// Directed scoreboard bench for mar_burst: a wrapping and a saturating instance,
// plus a LIMIT=7 instance when MAR_BOUNDS_CHECK_EN is defined.
module tb_mar_burst;

  logic       clk;
  logic       rst_n;
  logic       ld;
  logic [4:0] addr_in;
  logic       inc;
  logic       burst_start;
  logic [3:0] burst_len;
  logic       mem_ack;

  logic [4:0] addr, sat_addr;
  logic       mem_req, busy, done, fault;
  logic       sat_req, sat_busy, sat_done, sat_fault;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    string      tag;
    logic [4:0] addr;
    logic [4:0] sat;
    logic       req;
    logic       done;
  } exp_t;

  exp_t exp_q[$];

  mar_burst #(.AW(5), .LW(4), .STEP(1), .WRAP(1)) dut (
    .clk(clk), .rst_n(rst_n), .ld(ld), .addr_in(addr_in), .inc(inc),
    .burst_start(burst_start), .burst_len(burst_len), .mem_ack(mem_ack),
    .addr(addr), .mem_req(mem_req), .busy(busy), .done(done), .fault(fault)
  );

  mar_burst #(.AW(5), .LW(4), .STEP(1), .WRAP(0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ld(ld), .addr_in(addr_in), .inc(inc),
    .burst_start(burst_start), .burst_len(burst_len), .mem_ack(mem_ack),
    .addr(sat_addr), .mem_req(sat_req), .busy(sat_busy), .done(sat_done), .fault(sat_fault)
  );

`ifdef MAR_BOUNDS_CHECK_EN
  logic [4:0] lim_addr;
  logic       lim_req, lim_busy, lim_done, lim_fault;

  mar_burst #(.AW(5), .LW(4), .STEP(1), .WRAP(1), .LIMIT(7)) dut_lim (
    .clk(clk), .rst_n(rst_n), .ld(ld), .addr_in(addr_in), .inc(inc),
    .burst_start(burst_start), .burst_len(burst_len), .mem_ack(mem_ack),
    .addr(lim_addr), .mem_req(lim_req), .busy(lim_busy), .done(lim_done), .fault(lim_fault)
  );
`endif

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic compare(input string tag, input logic [7:0] obs, input logic [7:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  task automatic push_expect(input string tag, input logic [4:0] a, input logic [4:0] s,
                             input logic r, input logic d);
    exp_t e;
    e.tag  = tag;
    e.addr = a;
    e.sat  = s;
    e.req  = r;
    e.done = d;
    exp_q.push_back(e);
  endtask

  // Both instances never fault in these sequences (LIMIT defaults to all-ones).
  task automatic check_output();
    exp_t e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = exp_q.pop_front();
      compare({e.tag, ".addr"},      8'(addr),      8'(e.addr));
      compare({e.tag, ".sat_addr"},  8'(sat_addr),  8'(e.sat));
      compare({e.tag, ".mem_req"},   8'(mem_req),   8'(e.req));
      compare({e.tag, ".busy"},      8'(busy),      8'(e.req));
      compare({e.tag, ".done"},      8'(done),      8'(e.done));
      compare({e.tag, ".fault"},     8'(fault),     8'h00);
      compare({e.tag, ".sat_req"},   8'(sat_req),   8'(e.req));
      compare({e.tag, ".sat_done"},  8'(sat_done),  8'(e.done));
      compare({e.tag, ".sat_fault"}, 8'(sat_fault), 8'h00);
    end
  endtask

  task automatic apply_stimulus(input logic l, input logic [4:0] ain, input logic i,
                                input logic bs, input logic [3:0] bl, input logic ack,
                                input string tag, input logic [4:0] ea, input logic [4:0] es,
                                input logic er, input logic ed);
    ld          = l;
    addr_in     = ain;
    inc         = i;
    burst_start = bs;
    burst_len   = bl;
    mem_ack     = ack;
    push_expect(tag, ea, es, er, ed);
    @(posedge clk);
    #1;
    check_output();
  endtask

`ifdef MAR_BOUNDS_CHECK_EN
  task automatic check_lim(input string tag, input logic [4:0] a, input logic r,
                           input logic d, input logic f);
    compare({tag, ".lim_addr"},  8'(lim_addr),  8'(a));
    compare({tag, ".lim_req"},   8'(lim_req),   8'(r));
    compare({tag, ".lim_busy"},  8'(lim_busy),  8'(r));
    compare({tag, ".lim_done"},  8'(lim_done),  8'(d));
    compare({tag, ".lim_fault"}, 8'(lim_fault), 8'(f));
  endtask
`endif

  initial begin
    logic [4:0] stall_addr [6];
    stall_addr = '{5'h04, 5'h04, 5'h05, 5'h05, 5'h06, 5'h06};

    clk = 1'b0; rst_n = 1'b0; ld = 1'b0; addr_in = 5'h00; inc = 1'b0;
    burst_start = 1'b0; burst_len = 4'h0; mem_ack = 1'b0;
    #7;
    push_expect("reset", 5'h00, 5'h00, 1'b0, 1'b0);
    check_output();
    #5;
    rst_n = 1'b1;

    // load and single steps
    apply_stimulus(1'b1, 5'h0A, 1'b0, 1'b0, 4'd0, 1'b0, "ld_0a",  5'h0A, 5'h0A, 1'b0, 1'b0);
    apply_stimulus(1'b0, 5'h00, 1'b1, 1'b0, 4'd0, 1'b0, "inc_0b", 5'h0B, 5'h0B, 1'b0, 1'b0);
    apply_stimulus(1'b0, 5'h00, 1'b1, 1'b0, 4'd0, 1'b0, "inc_0c", 5'h0C, 5'h0C, 1'b0, 1'b0);

    // 4-beat burst, ack held high
    apply_stimulus(1'b1, 5'h03, 1'b0, 1'b0, 4'd0, 1'b0, "ld_03",  5'h03, 5'h03, 1'b0, 1'b0);
    apply_stimulus(1'b0, 5'h00, 1'b0, 1'b1, 4'd3, 1'b1, "b_start", 5'h03, 5'h03, 1'b1, 1'b0);
    apply_stimulus(1'b0, 5'h00, 1'b0, 1'b0, 4'd0, 1'b1, "b_beat1", 5'h04, 5'h04, 1'b1, 1'b0);
    apply_stimulus(1'b0, 5'h00, 1'b0, 1'b0, 4'd0, 1'b1, "b_beat2", 5'h05, 5'h05, 1'b1, 1'b0);
    apply_stimulus(1'b0, 5'h00, 1'b0, 1'b0, 4'd0, 1'b1, "b_beat3", 5'h06, 5'h06, 1'b1, 1'b0);
    apply_stimulus(1'b0, 5'h00, 1'b0, 1'b0, 4'd0, 1'b1, "b_done",  5'h06, 5'h06, 1'b0, 1'b1);
    apply_stimulus(1'b0, 5'h00, 1'b0, 1'b0, 4'd0, 1'b0, "b_idle",  5'h06, 5'h06, 1'b0, 1'b0);

    // same burst with ack toggling 1,0,1,0
    apply_stimulus(1'b1, 5'h03, 1'b0, 1'b0, 4'd0, 1'b0, "s_ld",    5'h03, 5'h03, 1'b0, 1'b0);
    apply_stimulus(1'b0, 5'h00, 1'b0, 1'b1, 4'd3, 1'b0, "s_start", 5'h03, 5'h03, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++)
      apply_stimulus(1'b0, 5'h00, 1'b0, 1'b0, 4'd0, (i % 2) == 0, $sformatf("s_beat%0d", i),
                     stall_addr[i], stall_addr[i], 1'b1, 1'b0);
    apply_stimulus(1'b0, 5'h00, 1'b0, 1'b0, 4'd0, 1'b1, "s_done",  5'h06, 5'h06, 1'b0, 1'b1);
    apply_stimulus(1'b0, 5'h00, 1'b0, 1'b0, 4'd0, 1'b0, "s_idle",  5'h06, 5'h06, 1'b0, 1'b0);

    // ld aborts a burst even with a coincident ack
    apply_stimulus(1'b1, 5'h03, 1'b0, 1'b0, 4'd0, 1'b0, "a_ld",    5'h03, 5'h03, 1'b0, 1'b0);
    apply_stimulus(1'b0, 5'h00, 1'b0, 1'b1, 4'd3, 1'b0, "a_start", 5'h03, 5'h03, 1'b1, 1'b0);
    apply_stimulus(1'b0, 5'h00, 1'b0, 1'b0, 4'd0, 1'b1, "a_beat",  5'h04, 5'h04, 1'b1, 1'b0);
    apply_stimulus(1'b1, 5'h10, 1'b0, 1'b0, 4'd0, 1'b1, "a_abort", 5'h10, 5'h10, 1'b0, 1'b0);
    apply_stimulus(1'b0, 5'h00, 1'b0, 1'b0, 4'd0, 1'b0, "a_idle",  5'h10, 5'h10, 1'b0, 1'b0);

    // command priority, ignored inc in BURST, and DONE accepting a command
    apply_stimulus(1'b1, 5'h05, 1'b1, 1'b1, 4'd2, 1'b0, "p_ld",    5'h05, 5'h05, 1'b0, 1'b0);
    apply_stimulus(1'b0, 5'h00, 1'b1, 1'b1, 4'd0, 1'b0, "p_bs",    5'h05, 5'h05, 1'b1, 1'b0);
    apply_stimulus(1'b0, 5'h00, 1'b1, 1'b1, 4'd0, 1'b0, "p_hold",  5'h05, 5'h05, 1'b1, 1'b0);
    apply_stimulus(1'b0, 5'h00, 1'b0, 1'b0, 4'd0, 1'b1, "p_done",  5'h05, 5'h05, 1'b0, 1'b1);
    apply_stimulus(1'b0, 5'h00, 1'b1, 1'b0, 4'd0, 1'b0, "p_dinc",  5'h06, 5'h06, 1'b0, 1'b0);

    // asynchronous reset mid-burst
    apply_stimulus(1'b0, 5'h00, 1'b0, 1'b1, 4'd5, 1'b0, "r_start", 5'h06, 5'h06, 1'b1, 1'b0);
    apply_stimulus(1'b0, 5'h00, 1'b0, 1'b0, 4'd0, 1'b1, "r_beat",  5'h07, 5'h07, 1'b1, 1'b0);
    #2;
    mem_ack = 1'b0;
    rst_n   = 1'b0;
    #1;
    push_expect("r_async", 5'h00, 5'h00, 1'b0, 1'b0);
    check_output();
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(1'b0, 5'h00, 1'b0, 1'b0, 4'd0, 1'b1, "r_after", 5'h00, 5'h00, 1'b0, 1'b0);

    // overflow: wrap vs saturate, and a saturating burst keeps beating at all-ones
    apply_stimulus(1'b1, 5'h1F, 1'b0, 1'b0, 4'd0, 1'b0, "w_ld",    5'h1F, 5'h1F, 1'b0, 1'b0);
    apply_stimulus(1'b0, 5'h00, 1'b1, 1'b0, 4'd0, 1'b0, "w_inc",   5'h00, 5'h1F, 1'b0, 1'b0);
    apply_stimulus(1'b0, 5'h00, 1'b0, 1'b1, 4'd1, 1'b1, "w_start", 5'h00, 5'h1F, 1'b1, 1'b0);
    apply_stimulus(1'b0, 5'h00, 1'b0, 1'b0, 4'd0, 1'b1, "w_beat",  5'h01, 5'h1F, 1'b1, 1'b0);
    apply_stimulus(1'b0, 5'h00, 1'b0, 1'b0, 4'd0, 1'b1, "w_done",  5'h01, 5'h1F, 1'b0, 1'b1);

`ifdef MAR_BOUNDS_CHECK_EN
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(1'b1, 5'h06, 1'b0, 1'b0, 4'd0, 1'b0, "l_ld",    5'h06, 5'h06, 1'b0, 1'b0);
    check_lim("l_ld", 5'h06, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 5'h00, 1'b0, 1'b1, 4'd3, 1'b1, "l_start", 5'h06, 5'h06, 1'b1, 1'b0);
    check_lim("l_start", 5'h06, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 5'h00, 1'b0, 1'b0, 4'd0, 1'b1, "l_beat1", 5'h07, 5'h07, 1'b1, 1'b0);
    check_lim("l_beat1", 5'h07, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 5'h00, 1'b0, 1'b0, 4'd0, 1'b1, "l_refuse", 5'h08, 5'h08, 1'b1, 1'b0);
    check_lim("l_refuse", 5'h07, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b1, 5'h00, 1'b0, 1'b0, 4'd0, 1'b0, "l_clear", 5'h00, 5'h00, 1'b0, 1'b0);
    check_lim("l_clear", 5'h00, 1'b0, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
